// File: rtl/seq_pkg.sv
// seq_pkg: shared state types, pattern constant and pattern-tracking next-state helper
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_e;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4} model_e;
  localparam logic [3:0] PAT_1011 = 4'b1011;
  function automatic model_e model_next(input model_e s, input logic b, input logic [3:0] pat);
    int st, h, r;
    st = (s == M4) ? 0 : int'(s);
    h = ((int'(pat) >> (4 - st)) << 1) | int'(b);
    r = 0;
    for (int l = 1; l <= 4; l++)
      if (l <= st + 1 && (h & ((1 << l) - 1)) == (int'(pat) >> (4 - l))) r = l;
    return model_e'(r[2:0]);
  endfunction
endpackage

// File: rtl/seq_ref_model.sv
// seq_ref_model: non-overlapping Moore pattern tracker producing exp_y and a saturating match count
module seq_ref_model
  import seq_pkg::*;
#(
  parameter logic [3:0] PATTERN = PAT_1011,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             exp_y,
  output logic [CNT_W-1:0] match_cnt
);
  model_e m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // advance only on valid bits; count each entry into the match state until all-ones
  always_comb begin
    m_d = bit_valid ? model_next(m_q, bit_in, PATTERN) : m_q;
    cnt_d = (m_d == M4 && m_q != M4 && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  // model state and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_q <= M0;
      cnt_q <= '0;
    end else begin
      m_q <= m_d;
      cnt_q <= cnt_d;
    end
  end
  assign exp_y = m_q == M4;
  assign match_cnt = cnt_q;
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: loads a parallel frame over valid/ready and shifts it out MSB-first with expected detector output
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [3:0] PATTERN = PAT_1011,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_y,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  tx_e state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [IW-1:0] idx_q, idx_d;
  logic x_q, x_valid_q, done_q;
  logic hs;
  assign load_ready = state_q == IDLE;
  assign hs = load_valid & load_ready;
  // handshake, shift and bit-count sequencing
  always_comb begin
    state_d = state_q;
    sreg_d = sreg_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (hs) begin
        state_d = SHIFT;
        sreg_d = load_data;
        idx_d = IW'(WIDTH - 1);
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        idx_d = idx_q - 1'b1;
        state_d = (idx_q == '0) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; x/x_valid/done are registered from next-state values
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q <= '0;
      idx_q <= '0;
      x_q <= 1'b0;
      x_valid_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      idx_q <= idx_d;
      x_q <= (state_d == SHIFT) & sreg_d[WIDTH-1];
      x_valid_q <= state_d == SHIFT;
      done_q <= state_d == DONE;
    end
  end
  assign x = x_q;
  assign x_valid = x_valid_q;
  assign done = done_q;
  assign busy = state_q != IDLE;
  seq_ref_model #(.PATTERN(PATTERN), .CNT_W(CNT_W)) u_model (
    .clk      (clk),
    .reset    (reset),
    .bit_valid(x_valid_q),
    .bit_in   (x_q),
    .exp_y    (exp_y),
    .match_cnt(match_cnt)
  );
endmodule
